ysyx_23060025_mem_arbiter: RTL and testbench

Two-master arbiter sharing a single APB-style memory port between the instruction fetch path (IFU/icache refill, read-only) and the load/store unit (read/write). Sits between the IFU/LSU request ports and the SoC memory bridge. Grants one requester at a time, latches its request, runs a SETUP/ACCESS transfer, and routes the response back to the owner only.

---
 rtl/ysyx_23060025_mem_arbiter.sv | 151 +++++++++++++++
 tb/tb_ysyx_23060025_mem_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060025_mem_arbiter.sv
// Two-master (IFU read-only, LSU read/write) arbiter onto one APB-style memory port.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise the LSU has fixed priority.
module ysyx_23060025_mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clock,
    input  logic                    reset,

    input  logic                    ifu_psel_i,
    input  logic [ADDR_WIDTH-1:0]   ifu_paddr_i,
    output logic                    ifu_pready_o,
    output logic [DATA_WIDTH-1:0]   ifu_prdata_o,
    output logic                    ifu_perr_o,

    input  logic                    lsu_psel_i,
    input  logic                    lsu_pwrite_i,
    input  logic [ADDR_WIDTH-1:0]   lsu_paddr_i,
    input  logic [DATA_WIDTH-1:0]   lsu_pwdata_i,
    input  logic [DATA_WIDTH/8-1:0] lsu_pstrb_i,
    output logic                    lsu_pready_o,
    output logic [DATA_WIDTH-1:0]   lsu_prdata_o,
    output logic                    lsu_perr_o,

    output logic                    mem_psel_o,
    output logic                    mem_penable_o,
    output logic                    mem_pwrite_o,
    output logic [ADDR_WIDTH-1:0]   mem_paddr_o,
    output logic [DATA_WIDTH-1:0]   mem_pwdata_o,
    output logic [DATA_WIDTH/8-1:0] mem_pstrb_o,
    input  logic                    mem_pready_i,
    input  logic [DATA_WIDTH-1:0]   mem_prdata_i,
    input  logic                    mem_pslverr_i
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_e;

    state_e                  state_q, state_d;
    logic                    owner_q, owner_d;   // 0 = IFU, 1 = LSU
    logic                    write_q, write_d;
    logic [ADDR_WIDTH-1:0]   addr_q,  addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0]   strb_q,  strb_d;

    logic any_req;
    logic grant_lsu;
    logic xfer_done;

    assign any_req = ifu_psel_i | lsu_psel_i;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_owner_q, last_owner_d;

    // On contention the requester that was not served last wins.
    assign grant_lsu = lsu_psel_i & (~ifu_psel_i | ~last_owner_q);

    always_comb begin
        last_owner_d = last_owner_q;
        if (state_q == IDLE && any_req) begin
            last_owner_d = grant_lsu;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_owner_q <= 1'b1;
        end else begin
            last_owner_q <= last_owner_d;
        end
    end
`else
    // LSU first: a stalled load must not wait behind a fetch the IDU cannot consume.
    assign grant_lsu = lsu_psel_i;
`endif

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path can infer a latch.
        state_d = state_q;
        owner_d = owner_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        strb_d  = strb_q;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = SETUP;
                    owner_d = grant_lsu;
                    if (grant_lsu) begin
                        write_d = lsu_pwrite_i;
                        addr_d  = lsu_paddr_i;
                        wdata_d = lsu_pwdata_i;
                        strb_d  = lsu_pstrb_i;
                    end else begin
                        write_d = 1'b0;
                        addr_d  = ifu_paddr_i;
                        wdata_d = '0;
                        strb_d  = '1;
                    end
                end
            end
            SETUP:   state_d = ACCESS;
            ACCESS:  if (mem_pready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
        end
    end

    // Bus side is driven only from the latched request, never from live requester inputs.
    assign mem_psel_o    = (state_q != IDLE);
    assign mem_penable_o = (state_q == ACCESS);
    assign mem_pwrite_o  = write_q;
    assign mem_paddr_o   = addr_q;
    assign mem_pwdata_o  = wdata_q;
    assign mem_pstrb_o   = strb_q;

    assign xfer_done = (state_q == ACCESS) & mem_pready_i;

    assign ifu_pready_o = xfer_done & ~owner_q;
    assign lsu_pready_o = xfer_done &  owner_q;
    assign ifu_perr_o   = ifu_pready_o & mem_pslverr_i;
    assign lsu_perr_o   = lsu_pready_o & mem_pslverr_i;
    assign ifu_prdata_o = mem_prdata_i;
    assign lsu_prdata_o = mem_prdata_i;

endmodule

// File: tb/tb_ysyx_23060025_mem_arbiter.sv
// Self-checking bench for ysyx_23060025_mem_arbiter: directed scenarios plus random traffic
// checked cycle by cycle against a transaction-schedule model of the arbiter.
module tb_ysyx_23060025_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset;
    logic          ifu_psel_i;
    logic [AW-1:0] ifu_paddr_i;
    logic          ifu_pready_o;
    logic [DW-1:0] ifu_prdata_o;
    logic          ifu_perr_o;
    logic          lsu_psel_i;
    logic          lsu_pwrite_i;
    logic [AW-1:0] lsu_paddr_i;
    logic [DW-1:0] lsu_pwdata_i;
    logic [SW-1:0] lsu_pstrb_i;
    logic          lsu_pready_o;
    logic [DW-1:0] lsu_prdata_o;
    logic          lsu_perr_o;
    logic          mem_psel_o;
    logic          mem_penable_o;
    logic          mem_pwrite_o;
    logic [AW-1:0] mem_paddr_o;
    logic [DW-1:0] mem_pwdata_o;
    logic [SW-1:0] mem_pstrb_o;
    logic          mem_pready_i;
    logic [DW-1:0] mem_prdata_i;
    logic          mem_pslverr_i;

    ysyx_23060025_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clock(clock), .reset(reset),
        .ifu_psel_i(ifu_psel_i), .ifu_paddr_i(ifu_paddr_i), .ifu_pready_o(ifu_pready_o),
        .ifu_prdata_o(ifu_prdata_o), .ifu_perr_o(ifu_perr_o),
        .lsu_psel_i(lsu_psel_i), .lsu_pwrite_i(lsu_pwrite_i), .lsu_paddr_i(lsu_paddr_i),
        .lsu_pwdata_i(lsu_pwdata_i), .lsu_pstrb_i(lsu_pstrb_i), .lsu_pready_o(lsu_pready_o),
        .lsu_prdata_o(lsu_prdata_o), .lsu_perr_o(lsu_perr_o),
        .mem_psel_o(mem_psel_o), .mem_penable_o(mem_penable_o), .mem_pwrite_o(mem_pwrite_o),
        .mem_paddr_o(mem_paddr_o), .mem_pwdata_o(mem_pwdata_o), .mem_pstrb_o(mem_pstrb_o),
        .mem_pready_i(mem_pready_i), .mem_prdata_i(mem_prdata_i), .mem_pslverr_i(mem_pslverr_i)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    int t = 0;

    // Transaction-schedule model: a grant in cycle g completes in cycle g+2+w.
    bit            m_valid;
    int            m_g, m_done, m_w;
    bit            m_owner, m_last, m_write;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [SW-1:0] m_strb;
    int            next_w;

    int            slv_cnt;
    logic [DW-1:0] slv_data;
    bit            slv_err;

    bit            ifu_req, lsu_req;

    int            ifu_pr_cyc, lsu_pr_cyc, ifu_pr_cnt, lsu_pr_cnt, psel_first, pen_first;
    logic [DW-1:0] obs_ifu_rdata, obs_lsu_rdata;
    logic [AW-1:0] obs_paddr_done;
    bit            obs_ifu_err, obs_lsu_err;
    int            order[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0; m_owner = 1'b0; m_last = 1'b1; m_write = 1'b0;
        m_addr = '0; m_wdata = '0; m_strb = '0;
        m_g = -10; m_done = -10; m_w = 0; slv_cnt = 0;
    endtask

    task automatic clear_obs();
        ifu_pr_cyc = -1; lsu_pr_cyc = -1; ifu_pr_cnt = 0; lsu_pr_cnt = 0;
        psel_first = -1; pen_first = -1; obs_ifu_err = 0; obs_lsu_err = 0;
        obs_ifu_rdata = '0; obs_lsu_rdata = '0; obs_paddr_done = '0;
        order.delete();
    endtask

    function automatic bit model_idle();
        return !m_valid || (t > m_done);
    endfunction

    task automatic model_grant();
        bit win_lsu;
        if (model_idle() && (ifu_psel_i || lsu_psel_i)) begin
            if (RR && ifu_psel_i && lsu_psel_i) win_lsu = !m_last;
            else                                win_lsu = lsu_psel_i;
            m_last = win_lsu; m_owner = win_lsu; m_valid = 1'b1;
            m_g = t; m_w = next_w; m_done = t + 2 + next_w;
            if (win_lsu) begin
                m_addr = lsu_paddr_i; m_wdata = lsu_pwdata_i; m_strb = lsu_pstrb_i; m_write = lsu_pwrite_i;
            end else begin
                m_addr = ifu_paddr_i; m_strb = '1; m_write = 1'b0;
            end
        end
    endtask

    // One clock cycle: commit this cycle's inputs, then check the next cycle at its negedge.
    task automatic cycle();
        bit in_xfer, done;
        model_grant();
        @(posedge clock);
        t++;
        @(negedge clock);
        in_xfer = m_valid && (t >= m_g + 1) && (t <= m_done);
        check("mem_psel", mem_psel_o, in_xfer);
        check("mem_penable", mem_penable_o, in_xfer && (t >= m_g + 2));
        check("mem_pwrite", mem_pwrite_o, m_write);
        check("mem_paddr", mem_paddr_o, m_addr);
        check("mem_pstrb", mem_pstrb_o, m_strb);
        if (!(m_valid && !m_owner)) check("mem_pwdata", mem_pwdata_o, m_wdata);
        if (mem_psel_o && mem_penable_o) begin
            mem_pready_i = (slv_cnt == m_w);
            slv_cnt = mem_pready_i ? 0 : slv_cnt + 1;
        end else begin
            mem_pready_i = 1'b0;
            slv_cnt = 0;
        end
        mem_prdata_i  = slv_data;
        mem_pslverr_i = slv_err;
        #1;
        done = m_valid && (t == m_done);
        check("ifu_pready", ifu_pready_o, done && !m_owner);
        check("lsu_pready", lsu_pready_o, done && m_owner);
        check("ifu_perr", ifu_perr_o, done && !m_owner && slv_err);
        check("lsu_perr", lsu_perr_o, done && m_owner && slv_err);
        check("ifu_prdata", ifu_prdata_o, slv_data);
        check("lsu_prdata", lsu_prdata_o, slv_data);
        if (mem_psel_o && psel_first < 0) psel_first = t;
        if (mem_penable_o && pen_first < 0) pen_first = t;
        obs_ifu_err |= ifu_perr_o;
        obs_lsu_err |= lsu_perr_o;
        if (ifu_pready_o) begin
            ifu_pr_cyc = t; ifu_pr_cnt++; obs_ifu_rdata = ifu_prdata_o;
            obs_paddr_done = mem_paddr_o; order.push_back(0);
            ifu_req = 1'b0; ifu_psel_i = 1'b0;
        end
        if (lsu_pready_o) begin
            lsu_pr_cyc = t; lsu_pr_cnt++; obs_lsu_rdata = lsu_prdata_o;
            obs_paddr_done = mem_paddr_o; order.push_back(1);
            lsu_req = 1'b0; lsu_psel_i = 1'b0;
        end
    endtask

    task automatic run(input int max_cycles, input bit scramble_lsu);
        int n = 0;
        while ((ifu_req || lsu_req) && n < max_cycles) begin
            cycle();
            n++;
            if (scramble_lsu && lsu_req && mem_penable_o) lsu_paddr_i = '0;
        end
        check("run_completed", {ifu_req, lsu_req}, 2'b00);
        cycle();
    endtask

    task automatic lsu_request(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
        lsu_req = 1'b1; lsu_psel_i = 1'b1; lsu_pwrite_i = wr;
        lsu_paddr_i = a; lsu_pwdata_i = d; lsu_pstrb_i = s;
    endtask

    task automatic ifu_request(input logic [AW-1:0] a);
        ifu_req = 1'b1; ifu_psel_i = 1'b1; ifu_paddr_i = a;
    endtask

    task automatic check_bus_quiet(input string tag);
        check({tag, "_psel"}, mem_psel_o, 1'b0);
        check({tag, "_penable"}, mem_penable_o, 1'b0);
        check({tag, "_pwrite"}, mem_pwrite_o, 1'b0);
        check({tag, "_paddr"}, mem_paddr_o, '0);
        check({tag, "_pwdata"}, mem_pwdata_o, '0);
        check({tag, "_pstrb"}, mem_pstrb_o, '0);
        check({tag, "_ifu_pready"}, ifu_pready_o, 1'b0);
        check({tag, "_lsu_pready"}, lsu_pready_o, 1'b0);
        check({tag, "_ifu_perr"}, ifu_perr_o, 1'b0);
        check({tag, "_lsu_perr"}, lsu_perr_o, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit hit;
        reset = 1'b1;
        ifu_psel_i = 0; ifu_paddr_i = '0; ifu_req = 0;
        lsu_psel_i = 0; lsu_pwrite_i = 0; lsu_paddr_i = '0; lsu_pwdata_i = '0; lsu_pstrb_i = '0; lsu_req = 0;
        mem_pready_i = 0; mem_prdata_i = '0; mem_pslverr_i = 0;
        slv_data = '0; slv_err = 0; next_w = 0;
        model_reset();
        clear_obs();

        @(negedge clock);
        check_bus_quiet("reset");
        @(negedge clock);
        reset = 1'b0;

        // IFU fetch from a zero-wait slave
        clear_obs(); n = t;
        slv_data = 32'h0000_0413; next_w = 0;
        ifu_request(32'h8000_0000);
        run(10, 0);
        check("t1_psel_cycle", psel_first, n + 1);
        check("t1_penable_cycle", pen_first, n + 2);
        check("t1_pready_cycle", ifu_pr_cyc, n + 2);
        check("t1_rdata", obs_ifu_rdata, 32'h0000_0413);
        check("t1_lsu_pready_cnt", lsu_pr_cnt, 0);

        // LSU write with three wait states
        clear_obs(); n = t;
        slv_data = 32'h1234_5678; next_w = 3;
        lsu_request(1'b1, 32'h8000_1000, 32'hDEAD_BEEF, 4'b0011);
        run(12, 0);
        check("t2_pready_cycle", lsu_pr_cyc, n + 5);
        check("t2_pready_cnt", lsu_pr_cnt, 1);
        check("t2_ifu_pready_cnt", ifu_pr_cnt, 0);

        // Two contested rounds
        for (int r = 0; r < 2; r++) begin
            clear_obs();
            next_w = 1; slv_data = 32'hA5A5_0000 + r;
            ifu_request(32'h8000_0040 + r * 4);
            lsu_request(1'b0, 32'h8000_2000 + r * 4, 32'h0, 4'hF);
            run(20, 0);
            check("t3_count", order.size(), 2);
            check("t3_first", order[0], RR ? 0 : 1);
            check("t3_second", order[1], RR ? 1 : 0);
        end

        // LSU address changes after grant
        clear_obs();
        next_w = 2; slv_data = 32'h0BAD_F00D;
        lsu_request(1'b0, 32'h8000_1000, 32'h0, 4'hF);
        run(12, 1);
        check("t4_paddr_at_done", obs_paddr_done, 32'h8000_1000);
        check("t4_rdata", obs_lsu_rdata, 32'h0BAD_F00D);

        // LSU read with a slave error
        clear_obs();
        next_w = 0; slv_err = 1; slv_data = $urandom;
        lsu_request(1'b0, 32'h8000_3000, 32'h0, 4'hF);
        run(10, 0);
        check("t5_lsu_perr", obs_lsu_err, 1'b1);
        check("t5_ifu_perr", obs_ifu_err, 1'b0);
        check("t5_pready_cnt", lsu_pr_cnt, 1);
        slv_err = 0;

        // Reset while a transfer is stuck in ACCESS
        clear_obs();
        next_w = 100;
        ifu_request(32'h8000_0100);
        hit = 0;
        for (int i = 0; i < 5 && !hit; i++) begin
            cycle();
            hit = mem_penable_o;
        end
        check("t6_reached_access", hit, 1'b1);
        reset = 1'b1;
        #1;
        check_bus_quiet("t6_reset");
        ifu_req = 0; ifu_psel_i = 0;
        model_reset();
        mem_pready_i = 0;
        @(negedge clock);
        reset = 1'b0;
        clear_obs(); n = t;
        next_w = 1; slv_data = 32'h0010_0093;
        ifu_request(32'h8000_0004);
        run(10, 0);
        check("t6_pready_cycle", ifu_pr_cyc, n + 3);
        check("t6_rdata", obs_ifu_rdata, 32'h0010_0093);
        check("t6_pready_cnt", ifu_pr_cnt, 1);

        // Random traffic
        clear_obs();
        for (int i = 0; i < 600; i++) begin
            next_w = $urandom_range(0, 3);
            slv_data = $urandom;
            slv_err = 1'($urandom_range(0, 1));
            if (!ifu_req && $urandom_range(0, 2) == 0)
                ifu_request($urandom & 32'hFFFF_FFFC);
            if (!lsu_req && $urandom_range(0, 2) == 0)
                lsu_request(1'($urandom), $urandom & 32'hFFFF_FFFC, $urandom, 4'($urandom));
            cycle();
            if (m_valid && t < m_done) begin
                if (m_owner && lsu_req && $urandom_range(0, 3) == 0) begin
                    lsu_paddr_i = $urandom; lsu_pwdata_i = $urandom;
                    lsu_pstrb_i = 4'($urandom); lsu_pwrite_i = 1'($urandom);
                    if ($urandom_range(0, 3) == 0) lsu_psel_i = 1'b0;
                end
                if (!m_owner && ifu_req && $urandom_range(0, 3) == 0) begin
                    ifu_paddr_i = $urandom;
                    if ($urandom_range(0, 3) == 0) ifu_psel_i = 1'b0;
                end
            end
        end
        run(30, 0);
        check("rand_ifu_served", ifu_pr_cnt > 20, 1'b1);
        check("rand_lsu_served", lsu_pr_cnt > 20, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
